// File: rtl/data_compare_seq.sv
`default_nettype none
// ============================================================================
// data_compare_seq : sequential nibble-serial magnitude comparator (gt/lt/eq)
// Optional build macro: DATACOMPARE_EARLY_EXIT_EN (MSB-first with early exit)
// Revision: 1.0 - initial release
// ============================================================================
module data_compare_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic                   iClear,
  input  logic [4*NIBBLES-1:0]   iData_a,
  input  logic [4*NIBBLES-1:0]   iData_b,
  input  logic [2:0]             iData,
  output logic                   oReady,
  output logic                   oValid,
  output logic [2:0]             oData
);

  localparam int              IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NIBBLES-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]             res_q, res_d;
  logic [2:0]             data_q, data_d;
  logic [3:0]             nib_a, nib_b;

  // 4-bit cascade compare stage: equal nibbles pass the cascade bits verbatim
  function automatic logic [2:0] cmp_nib(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] cin);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return cin;
  endfunction

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= 3'b000;
      data_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      data_q  <= data_d;
    end
  end

  // res_q is the running ripple result (LSB-first) or the held cascade input (early exit)
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (iStart && !iClear) begin
          a_d     = iData_a;
          b_d     = iData_b;
          res_d   = iData;
          state_d = S_RUN;
`ifdef DATACOMPARE_EARLY_EXIT_EN
          idx_d   = LAST_IDX;
`else
          idx_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (iClear) begin
          state_d = S_IDLE;
        end else begin
`ifdef DATACOMPARE_EARLY_EXIT_EN
          if (nib_a != nib_b) begin
            data_d  = cmp_nib(nib_a, nib_b, res_q);
            state_d = S_DONE;
          end else if (idx_q == '0) begin
            data_d  = res_q;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
`else
          res_d = cmp_nib(nib_a, nib_b, res_q);
          if (idx_q == LAST_IDX) begin
            data_d  = res_d;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign oReady = (state_q == S_IDLE);
  assign oValid = (state_q == S_DONE);
  assign oData  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_data_compare_seq.sv
`default_nettype none
// ============================================================================
// tb_data_compare_seq : randomized self-checking bench for data_compare_seq
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_compare_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         iStart;
  logic         iClear;
  logic [W-1:0] iData_a;
  logic [W-1:0] iData_b;
  logic [2:0]   iData;
  logic         oReady;
  logic         oValid;
  logic [2:0]   oData;

  int n_chk;
  int n_fail;

  data_compare_seq #(.NIBBLES(N)) dut (
    .iClk    (clk),
    .iRst    (rst),
    .iStart  (iStart),
    .iClear  (iClear),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .iData   (iData),
    .oReady  (oReady),
    .oValid  (oValid),
    .oData   (oData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word magnitude compare, cascade only when fully equal
  function automatic logic [2:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] c);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return c;
  endfunction

  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DATACOMPARE_EARLY_EXIT_EN
    int k;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i*4 +: 4] != b[i*4 +: 4]) break;
      k++;
    end
    return (k >= N) ? N : k + 1;
`else
    return N;
`endif
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    @(negedge clk);
    iData_a = a;
    iData_b = b;
    iData   = c;
    iStart  = 1'b1;
    @(posedge clk);
    #1;
    iStart  = 1'b0;
  endtask

  task automatic run_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(oReady), 32'd1);
    start_op(a, b, c);
    lat = 0;
    while (!oValid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(ref_latency(a, b)));
    check({tag, "_data"}, 32'(oData), 32'(ref_result(a, b, c)));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(oValid), 32'd0);
    check({tag, "_idle"}, 32'(oReady), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [W-1:0] a, b;
    logic [2:0] c, prev;
    int pos;
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    iStart  = 1'b0;
    iClear  = 1'b0;
    iData_a = '0;
    iData_b = '0;
    iData   = 3'b000;
    #23;
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_data", 32'(oData), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_cmp("equal", 16'h1234, 16'h1234, 3'b001);
    run_cmp("msb", 16'h8000, 16'h7FFF, 3'b010);
    run_cmp("lsb", 16'h0001, 16'h0002, 3'b001);
    run_cmp("passthru", 16'hFFFF, 16'hFFFF, 3'b110);
    run_cmp("zero_casc", 16'h0000, 16'h0000, 3'b000);

    // asynchronous reset between clock edges, two nibbles into a compare
    start_op(16'h1238, 16'h1234, 3'b001);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_data", 32'(oData), 32'd0);
    check("midrst_ready", 32'(oReady), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_cmp("after_rst", 16'h0003, 16'h0003, 3'b001);

    // iStart while busy must be ignored
    start_op(16'h1238, 16'h1234, 3'b001);
    @(negedge clk);
    iData_a = 16'h0000;
    iData_b = 16'hFFFF;
    iStart  = 1'b1;
    @(negedge clk);
    iStart  = 1'b0;
    pos = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (oValid) begin
        pos++;
        check("busy_data", 32'(oData), 32'b100);
      end
    end
    check("busy_pulses", 32'(pos), 32'd1);

    // iClear sampled at E2 aborts with no pulse and keeps the old result
    run_cmp("pre_clear", 16'h0001, 16'h0002, 3'b001);
    start_op(16'h1238, 16'h1234, 3'b001);
    @(posedge clk);
    #1;
    iClear = 1'b1;
    @(posedge clk);
    #1;
    iClear = 1'b0;
    check("clear_ready", 32'(oReady), 32'd1);
    pos = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (oValid) pos++;
    end
    check("clear_nopulse", 32'(pos), 32'd0);
    check("clear_hold", 32'(oData), 32'b010);

    // clear has priority over start in IDLE
    @(negedge clk);
    iStart = 1'b1;
    iClear = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iClear = 1'b0;
    check("clr_prio", 32'(oReady), 32'd1);

    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      a = r[W-1:0];
      r = $urandom;
      b = r[W-1:0];
      r = $urandom;
      c = r[2:0];
      case ($urandom_range(0, 2))
        0: b = a;
        1: begin
          b = a;
          pos = $urandom_range(0, N - 1);
          b[pos*4 +: 4] = a[pos*4 +: 4] ^ 4'($urandom_range(1, 15));
        end
        default: ;
      endcase
      prev = ref_result(a, b, c);
      run_cmp($sformatf("rand%0d", t), a, b, c);
      check($sformatf("rand%0d_hold", t), 32'(oData), 32'(prev));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
